// File: rtl/hex_display_pkg.sv
// Shared constants for the hex display scanner: blank pattern, glyph table
// and the nibble-to-segment lookup used by the glyph ROM.
package hex_display_pkg;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Active-low {g,f,e,d,c,b,a} patterns for nibbles 0..F.
   localparam logic [6:0] GLYPH_TABLE [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30,
      7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03,
      7'h46, 7'h21, 7'h06, 7'h0E
   };

   function automatic logic [6:0] glyph(input logic [3:0] nibble);
      return GLYPH_TABLE[nibble];
   endfunction

endpackage

// File: rtl/hex_display_scanner_if.sv
// Bus between the datapath and the hex display scanner: value/dp capture
// strobe and the registered, active-low display pin drive.
interface hex_display_scanner_if #(
   parameter int DIGITS = 4
);

   // load is a single-cycle strobe with no back-pressure: value and dp are
   // sampled on every rising edge where load is high, and the last one before
   // a frame wrap is what the next frame shows. enable gates scanning only.
   logic                  enable;
   logic [4*DIGITS-1:0]   value;
   logic [DIGITS-1:0]     dp;
   logic                  load;
   logic [6:0]            seg_n;
   logic                  dp_n;
   logic [DIGITS-1:0]     an_n;
   logic                  frame_tick;

   modport master (
      output enable, value, dp, load,
      input  seg_n, dp_n, an_n, frame_tick
   );

   modport slave (
      input  enable, value, dp, load,
      output seg_n, dp_n, an_n, frame_tick
   );

endinterface

// File: rtl/hex_glyph_rom.sv
// Combinational nibble-to-seven-segment decoder (active-low outputs).
module hex_glyph_rom
   import hex_display_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg_n
);

   assign seg_n = glyph(nibble);

endmodule

// File: rtl/hex_display_scanner.sv
// Time-multiplexed common-anode hex display driver with a double-buffered
// value; define HEX_DISPLAY_LZB_EN to blank leading zero digits.
module hex_display_scanner
   import hex_display_pkg::*;
#(
   parameter int DIGITS   = 4,
   parameter int PRESCALE = 50000
) (
   input  logic                 clock,
   input  logic                 reset,
   hex_display_scanner_if.slave bus
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

   logic [PW-1:0]        presc;
   logic [IW-1:0]        idx;
   logic [4*DIGITS-1:0]  act_val;
   logic [DIGITS-1:0]    act_dp;
   logic [4*DIGITS-1:0]  pend_val;
   logic [DIGITS-1:0]    pend_dp;
   logic                 pend_valid;
   logic                 wrap_seen;

   logic                 presc_tc;
   logic                 wrap;
   logic [3:0]           cur_nib;
   logic                 cur_dp;
   logic [DIGITS-1:0]    an_dec;
   logic [6:0]           rom_seg;
   logic                 blank_cur;

   assign presc_tc = bus.enable && (presc == PRE_LAST);
   assign wrap     = presc_tc && (idx == IDX_LAST);

   always_comb begin
      cur_nib = 4'h0;
      cur_dp  = 1'b0;
      an_dec  = '1;
      for (int k = 0; k < DIGITS; k++) begin
         if (idx == IW'(k)) begin
            cur_nib   = act_val[4*k +: 4];
            cur_dp    = act_dp[k];
            an_dec[k] = 1'b0;
         end
      end
   end

   hex_glyph_rom u_glyph_rom (
      .nibble (cur_nib),
      .seg_n  (rom_seg)
   );

`ifdef HEX_DISPLAY_LZB_EN
   logic [DIGITS-1:0] lead_zero;
   logic              lz_run;

   // A digit is a leading zero when it and everything above it is zero with no dp.
   always_comb begin
      lead_zero = '0;
      lz_run    = 1'b1;
      blank_cur = 1'b0;
      for (int k = DIGITS - 1; k >= 0; k--) begin
         lz_run       = lz_run && (act_val[4*k +: 4] == 4'h0) && !act_dp[k];
         lead_zero[k] = lz_run && (k != 0);
      end
      for (int k = 0; k < DIGITS; k++) begin
         if (idx == IW'(k)) begin
            blank_cur = lead_zero[k];
         end
      end
   end
`else
   assign blank_cur = 1'b0;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         presc <= '0;
         idx   <= '0;
      end else if (bus.enable) begin
         if (presc_tc) begin
            presc <= '0;
            idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
         end else begin
            presc <= presc + 1'b1;
         end
      end
   end

   // A load on the wrap edge bypasses the pending buffer.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         act_val    <= '0;
         act_dp     <= '0;
         pend_val   <= '0;
         pend_dp    <= '0;
         pend_valid <= 1'b0;
      end else begin
         if (bus.load) begin
            pend_val <= bus.value;
            pend_dp  <= bus.dp;
         end
         if (wrap) begin
            pend_valid <= 1'b0;
            if (bus.load) begin
               act_val <= bus.value;
               act_dp  <= bus.dp;
            end else if (pend_valid) begin
               act_val <= pend_val;
               act_dp  <= pend_dp;
            end
         end else if (bus.load) begin
            pend_valid <= 1'b1;
         end
      end
   end

   // Held across a disabled stretch so the tick always lands with digit 0.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wrap_seen <= 1'b0;
      end else if (wrap) begin
         wrap_seen <= 1'b1;
      end else if (bus.enable) begin
         wrap_seen <= 1'b0;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         bus.seg_n      <= SEG_BLANK;
         bus.dp_n       <= 1'b1;
         bus.an_n       <= '1;
         bus.frame_tick <= 1'b0;
      end else if (bus.enable) begin
         bus.seg_n      <= blank_cur ? SEG_BLANK : rom_seg;
         bus.dp_n       <= blank_cur | ~cur_dp;
         bus.an_n       <= an_dec;
         bus.frame_tick <= wrap_seen;
      end else begin
         bus.seg_n      <= SEG_BLANK;
         bus.dp_n       <= 1'b1;
         bus.an_n       <= '1;
         bus.frame_tick <= 1'b0;
      end
   end

endmodule

// File: tb/tb_hex_display_scanner.sv
// Self-checking bench for hex_display_scanner with DIGITS=4, PRESCALE=4:
// scan timing, glyphs, tear-free buffering, enable and async reset.
module tb_hex_display_scanner;

   localparam int DIGITS   = 4;
   localparam int PRESCALE = 4;

   typedef struct packed {
      int          at;
      logic [15:0] val;
      logic [3:0]  dp;
      logic        push;
   } ld_t;

   localparam ld_t NO_LD = '{at: -1, val: 16'h0, dp: 4'h0, push: 1'b0};

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;
   logic [31:0] exp_q[$];

   hex_display_scanner_if #(.DIGITS(DIGITS)) bus ();

   hex_display_scanner #(
      .DIGITS   (DIGITS),
      .PRESCALE (PRESCALE)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   // ---------------- clock / reset ----------------
   always #5 clock = ~clock;

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic logic [6:0] ref_glyph(input logic [3:0] n);
      case (n)
         4'h0: return 7'h40;  4'h1: return 7'h79;
         4'h2: return 7'h24;  4'h3: return 7'h30;
         4'h4: return 7'h19;  4'h5: return 7'h12;
         4'h6: return 7'h02;  4'h7: return 7'h78;
         4'h8: return 7'h00;  4'h9: return 7'h10;
         4'hA: return 7'h08;  4'hB: return 7'h03;
         4'hC: return 7'h46;  4'hD: return 7'h21;
         4'hE: return 7'h06;  default: return 7'h0E;
      endcase
   endfunction

   // Frame word: [31:28] dp_n per digit, [7k+6:7k] seg_n of digit k.
   function automatic logic [31:0] exp_frame(input logic [15:0] val, input logic [3:0] dpv);
      logic [31:0] f;
      logic        lead;
      logic        blank;
      logic [3:0]  nib;
      f    = '0;
      lead = 1'b1;
      for (int k = 3; k >= 0; k--) begin
         nib   = val[4*k +: 4];
         lead  = lead && (nib == 4'h0) && !dpv[k];
`ifdef HEX_DISPLAY_LZB_EN
         blank = lead && (k != 0);
`else
         blank = 1'b0;
`endif
         f[7*k +: 7] = blank ? 7'h7F : ref_glyph(nib);
         f[28 + k]   = blank ? 1'b1 : ~dpv[k];
      end
      return f;
   endfunction

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic step();
      @(negedge clock);
   endtask

   task automatic drive_load(input logic [15:0] val, input logic [3:0] dpv, input logic push);
      bus.value = val;
      bus.dp    = dpv;
      bus.load  = 1'b1;
      if (push) exp_q.push_back(exp_frame(val, dpv));
   endtask

   task automatic load_once(input logic [15:0] val, input logic [3:0] dpv, input logic push);
      drive_load(val, dpv, push);
      step();
      bus.load = 1'b0;
   endtask

   task automatic wait_tick();
      for (int n = 0; n < 40 && bus.frame_tick !== 1'b1; n++) step();
      chk("tick_seen", {31'b0, bus.frame_tick}, 32'd1);
   endtask

   // Starts on the negedge showing frame_tick; ends on the next one.
   task automatic capture_frame(input string tag, input ld_t la, input ld_t lb);
      logic [31:0] obs;
      logic [3:0]  one;
      logic [3:0]  an_e;
      int          digit;
      obs = '0;
      one = 4'b0001;
      for (int i = 0; i < 16; i++) begin
         digit = i / 4;
         an_e  = ~(one << digit);
         chk({tag, "_an"}, {27'b0, bus.frame_tick, bus.an_n}, {27'b0, (i == 0), an_e});
         obs[7*digit +: 7] = bus.seg_n;
         obs[28 + digit]   = bus.dp_n;
         bus.load = 1'b0;
         if (la.at == i) drive_load(la.val, la.dp, la.push);
         if (lb.at == i) drive_load(lb.val, lb.dp, lb.push);
         step();
      end
      bus.load = 1'b0;
      if (exp_q.size() == 0) chk({tag, "_q_empty"}, 32'd1, 32'd0);
      else                   chk({tag, "_frame"}, obs, exp_q.pop_front());
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [31:0] f0;
      logic [31:0] f5678;
      logic [3:0]  one;
      logic [3:0]  an_e;
      int          d;

      one        = 4'b0001;
      bus.enable = 1'b1;
      bus.load   = 1'b0;
      bus.value  = '0;
      bus.dp     = '0;
      reset      = 1'b1;
      repeat (3) step();

      chk("rst_seg",  {25'b0, bus.seg_n},      32'h7F);
      chk("rst_dp",   {31'b0, bus.dp_n},       32'h1);
      chk("rst_an",   {28'b0, bus.an_n},       32'hF);
      chk("rst_tick", {31'b0, bus.frame_tick}, 32'h0);

      // Reset release and free-running scan over two frames.
      f0    = exp_frame(16'h0000, 4'h0);
      reset = 1'b0;
      for (int c = 0; c < 32; c++) begin
         step();
         d    = (c / 4) % 4;
         an_e = ~(one << d);
         chk("scan", {20'b0, bus.frame_tick, bus.an_n, bus.seg_n},
             {20'b0, (c % 16 == 0) && (c != 0), an_e, f0[7*d +: 7]});
      end

      // Glyph sweep on digit 0.
      wait_tick();
      for (int n = 0; n < 16; n++) begin
         load_once(16'(n), 4'h0, 1'b1);
         wait_tick();
         capture_frame("glyph", NO_LD, NO_LD);
      end

      // Tear-free update: mid-frame load must not touch the current frame.
      load_once(16'h1234, 4'h0, 1'b1);
      wait_tick();
      capture_frame("f1234", NO_LD, NO_LD);
      exp_q.push_back(exp_frame(16'h1234, 4'h0));
      capture_frame("tear", '{at: 8, val: 16'hABCD, dp: 4'h0, push: 1'b1}, NO_LD);
      capture_frame("fabcd", NO_LD, NO_LD);

      // Pending 1111 overtaken by a load on the wrap edge itself.
      exp_q.push_back(exp_frame(16'hABCD, 4'h0));
      capture_frame("wrap_pre", '{at: 4, val: 16'h1111, dp: 4'h0, push: 1'b0},
                    '{at: 14, val: 16'h5678, dp: 4'h0, push: 1'b1});
      capture_frame("wrap_ld", NO_LD, NO_LD);

      // Enable low while digit 1 is active; a load made while disabled still lands.
      f5678 = exp_frame(16'h5678, 4'h0);
      repeat (5) step();
      chk("en_pre", {21'b0, bus.an_n, bus.seg_n}, {21'b0, 4'b1101, f5678[13:7]});
      bus.enable = 1'b0;
      load_once(16'h9A0C, 4'h0, 1'b1);
      for (int j = 0; j < 6; j++) begin
         chk("en_off", {19'b0, bus.frame_tick, bus.dp_n, bus.an_n, bus.seg_n},
             {19'b0, 1'b0, 1'b1, 4'hF, 7'h7F});
         step();
      end
      bus.enable = 1'b1;
      for (int r = 0; r < 11; r++) begin
         step();
         d    = (r < 2) ? 1 : (r < 6) ? 2 : (r < 10) ? 3 : 0;
         an_e = ~(one << d);
         chk("en_resume", {27'b0, bus.frame_tick, bus.an_n}, {27'b0, (r == 10), an_e});
         if (r == 0) chk("en_resume_seg", {25'b0, bus.seg_n}, {25'b0, f5678[13:7]});
      end
      capture_frame("en_ld", NO_LD, NO_LD);

      // Leading-zero patterns (blanked only when the feature is built in).
      load_once(16'h0040, 4'h0, 1'b1);
      wait_tick();
      capture_frame("lz0", NO_LD, NO_LD);
      load_once(16'h0040, 4'b1000, 1'b1);
      wait_tick();
      capture_frame("lz1", NO_LD, NO_LD);

      // Async reset mid-frame with a pending load that must be discarded.
      load_once(16'h7777, 4'h0, 1'b0);
      repeat (4) step();
      #2;
      reset = 1'b1;
      #1;
      chk("arst_seg",  {25'b0, bus.seg_n},      32'h7F);
      chk("arst_dp",   {31'b0, bus.dp_n},       32'h1);
      chk("arst_an",   {28'b0, bus.an_n},       32'hF);
      chk("arst_tick", {31'b0, bus.frame_tick}, 32'h0);
      step();
      reset = 1'b0;
      step();
      chk("arst_first", {21'b0, bus.an_n, bus.seg_n}, {21'b0, 4'b1110, f0[6:0]});
      exp_q.push_back(f0);
      wait_tick();
      capture_frame("post_rst", NO_LD, NO_LD);

      chk("q_drain", exp_q.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
